// File: rtl/flow_light_pkg.sv
// flow_light_pkg: shared mode codes, default step periods and LED pattern helpers for flow_light_ctrl.
package flow_light_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'b00;
    localparam logic [1:0] MODE_ROT_R  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    localparam int unsigned DEF_DIV0 = 1000000;
    localparam int unsigned DEF_DIV1 = 10000000;
    localparam int unsigned DEF_DIV2 = 25000000;
    localparam int unsigned DEF_DIV3 = 100000000;

    localparam logic [7:0] LED_INIT = 8'h01;

    typedef enum logic {DIR_L, DIR_R} dir_e;

    function automatic logic [7:0] next_led(input logic [1:0] mode, input logic [7:0] led, input dir_e dir);
        return mode == MODE_ROT_L  ? {led[6:0], led[7]} :
               mode == MODE_ROT_R  ? {led[0], led[7:1]} :
               mode == MODE_BOUNCE ? (dir == DIR_L ? {led[6:0], 1'b0} : {1'b0, led[7:1]}) :
               (&led ? 8'h00 : {led[6:0], 1'b1});
    endfunction

    // Direction flips on the step that lands on an end bit, so endpoints are shown once.
    function automatic dir_e next_dir(input logic [7:0] led, input dir_e dir);
        return dir == DIR_L ? (led[6] ? DIR_R : DIR_L) : (led[1] ? DIR_L : DIR_R);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchroniser for a raw button followed by a one-cycle rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_m, r_s0, r_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m  <= 1'b0;
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_m  <= i_btn;
            r_s0 <= r_m;
            r_s1 <= r_s0;
        end
    end

    assign o_pulse = r_s0 & ~r_s1;

endmodule

// File: rtl/flow_light_ctrl.sv
// flow_light_ctrl: button-driven mode/run sequencer for an 8-LED flowing light with selectable step period.
// Optional FLOW_AUTO_MODE_EN: auto-advance the mode after AUTO_STEPS applied steps.
module flow_light_ctrl
    import flow_light_pkg::*;
#(
    parameter int unsigned DIV0 = DEF_DIV0,
    parameter int unsigned DIV1 = DEF_DIV1,
    parameter int unsigned DIV2 = DEF_DIV2,
    parameter int unsigned DIV3 = DEF_DIV3
`ifdef FLOW_AUTO_MODE_EN
    ,
    parameter int unsigned AUTO_STEPS = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_mode,
    input  logic [1:0] freq_set,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       running,
    output logic       step
);

    logic        w_run_p, w_mode_p, w_tick, w_adv;
    logic [31:0] w_period;
    logic [31:0] r_cnt;
    logic [7:0]  r_led;
    logic [1:0]  r_mode;
    logic        r_running, r_step;
    dir_e        r_dir;

    btn_edge u_run  (.clk(clk), .rst(rst), .i_btn(btn_run),  .o_pulse(w_run_p));
    btn_edge u_mode (.clk(clk), .rst(rst), .i_btn(btn_mode), .o_pulse(w_mode_p));

    always_comb begin
        w_period = freq_set == 2'd0 ? DIV0 :
                   freq_set == 2'd1 ? DIV1 :
                   freq_set == 2'd2 ? DIV2 : DIV3;
    end

    // >= rather than == so a switch to a shorter period ticks at once instead of wrapping.
    assign w_tick = r_running && (r_cnt >= w_period - 32'd1);

`ifdef FLOW_AUTO_MODE_EN
    logic [31:0] r_steps;

    assign w_adv = w_mode_p || (r_steps == AUTO_STEPS);

    always_ff @(posedge clk) begin
        if (rst || w_adv)
            r_steps <= 32'd0;
        else if (w_tick)
            r_steps <= r_steps + 32'd1;
    end
`else
    assign w_adv = w_mode_p;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led     <= LED_INIT;
            r_mode    <= MODE_ROT_L;
            r_running <= 1'b0;
            r_step    <= 1'b0;
            r_cnt     <= 32'd0;
            r_dir     <= DIR_L;
        end else begin
            r_step <= 1'b0;
            if (w_run_p)
                r_running <= ~r_running;
            if (w_adv) begin
                r_mode <= r_mode + 2'd1;
                r_led  <= LED_INIT;
                r_dir  <= DIR_L;
                r_cnt  <= 32'd0;
            end else if (w_tick) begin
                r_led  <= next_led(r_mode, r_led, r_dir);
                r_dir  <= r_mode == MODE_BOUNCE ? next_dir(r_led, r_dir) : r_dir;
                r_cnt  <= 32'd0;
                r_step <= 1'b1;
            end else if (r_running) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign led     = r_led;
    assign mode    = r_mode;
    assign running = r_running;
    assign step    = r_step;

endmodule

// File: doc/flow_light_ctrl.md
Name: flow_light_ctrl

Overview:
Mode and step controller for the 8-LED flowing-light display. It synchronises two push-buttons and generates a programmable step tick from freq_set. A four-state mode FSM sequences the LED pattern: rotate left, rotate right, bounce, or fill. The block sits between the board buttons/switches and the LED pins and replaces free-running rotation with user-controlled sequencing.

Parameters:
DIV0, 1000000, step period in clk cycles for freq_set=00
DIV1, 10000000, step period for freq_set=01
DIV2, 25000000, step period for freq_set=10
DIV3, 100000000, step period for freq_set=11
AUTO_STEPS, 32, steps per mode before auto-advance (used only with FLOW_AUTO_MODE_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
btn_run  in  1  raw button; each rising edge toggles run/pause
btn_mode  in  1  raw button; each rising edge advances mode
freq_set  in  2  selects step period DIV0..DIV3
led  out  8  LED pattern
mode  out  2  current mode (00 ROT_L, 01 ROT_R, 10 BOUNCE, 11 FILL)
running  out  1  1 = stepping enabled
step  out  1  one-cycle pulse on each applied LED update

Behaviour:
- Reset values, all synchronous on rst: led=8'h01, mode=ROT_L, running=0, step=0, tick counter=0, bounce dir=left, button sync flops=0.
- Button path: each button goes through a 2-flop synchroniser and then rising-edge detection (~s1 & s0). This gives a one-cycle pulse. Button effect appears in outputs 3 cycles after the raw rise. No debounce is performed.
- run_pulse toggles running.
- Tick counter: 32-bit. Increments only while running=1. When cnt >= period-1, tick=1 and cnt<=0. period = DIVn selected combinationally from freq_set.
  - The >= compare ensures a freq_set change to a shorter period ticks on the next cycle and never wraps.
- Pause: cnt and led hold their values; resume continues from the held cnt.
- On tick, led updates next cycle and step=1 in that same cycle:
  - ROT_L: {led[6:0],led[7]}
  - ROT_R: {led[0],led[7:1]}
  - BOUNCE: single bit moves left to bit7, dir flips, moves right to bit0, dir flips. Sequence 01,02,...,80,40,...,01,02; endpoints are not repeated.
  - FILL: 01,03,07,0F,1F,3F,7F,FF,00,01,...
- mode_pulse: mode <= mode+1 (wraps 11->00). In the same edge, led <= 8'h01, dir <= left, cnt <= 0, step=0.
- Simultaneous events:
  - mode_pulse with tick: the mode change wins and the tick is discarded.
  - run_pulse with mode_pulse: both apply.
  - run_pulse (pause) with tick: the tick is still applied.
- Reset mid-operation overrides everything on that edge.
- step is high only on cycles where led changed due to a tick.

Optional Feature:
Macro FLOW_AUTO_MODE_EN.
- Defined: a step counter counts applied ticks. After AUTO_STEPS ticks in one mode, the mode auto-advances with the same side effects as mode_pulse (led=01, cnt=0, dir=left). The step counter clears on any mode change and on reset. A mode_pulse coinciding with auto-advance advances by one only.
- Undefined: the mode changes only via btn_mode, and no step counter logic exists.

Decomposition:
- Package flow_light_pkg holds:
  - mode localparams MODE_ROT_L=2'b00, MODE_ROT_R=2'b01, MODE_BOUNCE=2'b10, MODE_FILL=2'b11
  - default DIV0..DIV3 constants
  - LED_INIT=8'h01
- Sub-module btn_edge (2-flop sync plus rising-edge pulse, sync active-high rst), instantiated for btn_run and btn_mode.

Test Plan:
- Reset, then btn_run rise with DIV0 overridden to 4, mode ROT_L -> running=1 three cycles later. led steps 01,02,04,...,80,01, one step every 4 cycles, with step pulsing each update.
- btn_mode to BOUNCE with DIV0=4 -> led=01 immediately after the mode change. Sequence 02,04,...,80,40,...,01,02 with no repeated endpoint.
- FILL mode -> 01,03,07,0F,1F,3F,7F,FF,00,01. Pause mid-sequence at 0F -> led holds 0F and cnt holds. Resume -> next value 1F after the remaining count.
- With DIV3=100 and cnt=50, switch freq_set to 00 (DIV0=4) -> tick on the next cycle, then every 4 cycles.
- Mode pulse on the same cycle as tick in ROT_R -> mode=BOUNCE, led=01, no step pulse. Assert rst mid-run -> all outputs at reset values on the next edge.
- FLOW_AUTO_MODE_EN, AUTO_STEPS=3, DIV0=2 -> mode advances after every 3 steps, wrapping FILL->ROT_L. Without the macro, mode stays at ROT_L indefinitely.
